// File: rtl/stream_tpose_pp.sv
// N x N streaming block transposer with ping-pong banks.
// Supports per-block bypass, EOS flush with zero padding, and a sticky error flag.
module stream_tpose_pp #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] a_d,
  input  logic [N-1:0]   a_e,
  input  logic [N-1:0]   a_v,
  output logic [N-1:0]   a_b,
  input  logic           mode,
  output logic [N*W-1:0] b_d,
  output logic [N-1:0]   b_e,
  output logic [N-1:0]   b_v,
  input  logic [N-1:0]   b_b,
  output logic           err
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [W-1:0] mem [2][N][N];

  logic [1:0]          full, full_n;
  logic [1:0]          bmode, bmode_n;
  logic                wr_bank, wr_n;
  logic                rd_bank, rd_n;
  logic [CW-1:0]       fill_cnt, fill_n;
  logic [CW-1:0]       drain_cnt, drain_n;
  logic                eos_pend, eos_n;
  logic                blk, blk_n;
  logic                err_n;
  logic                in_go, out_go;
  logic                ov, oe, is_eos;
  logic [1:0][N-1:0]   row_we;

  assign is_eos = a_e[0];
  assign in_go  = (&a_v) & ~blk;
  assign oe     = eos_pend & ~(|full);
  assign ov     = full[rd_bank] | oe;
  assign out_go = ov & ~(|b_b);

  assign a_b = {N{blk}};
  assign b_v = {N{ov}};
  assign b_e = {N{oe}};

  always_comb begin
    full_n  = full;
    bmode_n = bmode;
    wr_n    = wr_bank;
    rd_n    = rd_bank;
    fill_n  = fill_cnt;
    drain_n = drain_cnt;
    eos_n   = eos_pend;
    err_n   = err | ((&a_v) & (|a_e) & ~(&a_e));
    if (in_go) begin
      if (!is_eos) begin
        if (fill_cnt == '0) bmode_n[wr_bank] = mode;
        if (fill_cnt == LAST) begin
          full_n[wr_bank] = 1'b1;
          wr_n            = ~wr_bank;
          fill_n          = '0;
        end else begin
          fill_n = fill_cnt + 1'b1;
        end
      end else begin
        eos_n = 1'b1;
        if (fill_cnt != '0) begin
          full_n[wr_bank] = 1'b1;
          wr_n            = ~wr_bank;
          fill_n          = '0;
        end
      end
    end
    if (out_go) begin
      if (full[rd_bank]) begin
        if (drain_cnt == LAST) begin
          full_n[rd_bank] = 1'b0;
          rd_n            = ~rd_bank;
          drain_n         = '0;
        end else begin
          drain_n = drain_cnt + 1'b1;
        end
      end else begin
        eos_n = 1'b0;
      end
    end
    blk_n = full_n[wr_n] | eos_n;
  end

  // EOS zero-fills the rest of a partial block in one cycle
  always_comb begin
    row_we = '0;
    if (in_go) begin
      for (int r = 0; r < N; r++) begin
        if (is_eos)
          row_we[wr_bank][r] = (fill_cnt != '0) &&
                               (CW'(r) >= fill_cnt);
        else
          row_we[wr_bank][r] = (CW'(r) == fill_cnt);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full      <= '0;
      bmode     <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      fill_cnt  <= '0;
      drain_cnt <= '0;
      eos_pend  <= 1'b0;
      blk       <= 1'b1;
      err       <= 1'b0;
    end else begin
      full      <= full_n;
      bmode     <= bmode_n;
      wr_bank   <= wr_n;
      rd_bank   <= rd_n;
      fill_cnt  <= fill_n;
      drain_cnt <= drain_n;
      eos_pend  <= eos_n;
      blk       <= blk_n;
      err       <= err_n;
    end
  end

  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
        always_ff @(posedge clock) begin
          if (reset)
            mem[gb][gr][gc] <= '0;
          else if (row_we[gb][gr])
            mem[gb][gr][gc] <= is_eos ? '0 : a_d[gc*W +: W];
        end
      end
    end
  end

  always_comb begin
    b_d = '0;
    if (full[rd_bank]) begin
      for (int j = 0; j < N; j++) begin
        if (bmode[rd_bank])
          b_d[j*W +: W] = mem[rd_bank][drain_cnt[AW-1:0]][j];
        else
          b_d[j*W +: W] = mem[rd_bank][j][drain_cnt[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_stream_tpose_pp.sv
// Bench for stream_tpose_pp: queue-based block model checked every cycle,
// plus directed scenarios pinned by literal expectations.
module tb_stream_tpose_pp;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = 4;
  localparam int NW = N * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] a_d = '0;
  logic [N-1:0]  a_e = '0;
  logic [N-1:0]  a_v = '0;
  logic [N-1:0]  a_b;
  logic          mode = 1'b0;
  logic [NW-1:0] b_d;
  logic [N-1:0]  b_e;
  logic [N-1:0]  b_v;
  logic [N-1:0]  b_b = '0;
  logic          err;

  stream_tpose_pp #(.N(N), .W(W), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(a_b),
    .mode(mode),
    .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(b_b),
    .err(err)
  );

  always #5 clock = ~clock;

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Model: partial block rows plus a flat queue of pending output vectors
  logic [W-1:0]  rows [N][N];
  int            fill_m = 0;
  bit            mode_m = 0;
  logic [NW-1:0] outq [$];
  bit            eos_m = 0, err_m = 0, blk_m = 1, mv = 0;

  logic [NW-1:0] got [$];
  int            got_cyc [$];
  int            eos_cnt = 0;
  bit            mon_ab = 0, ab_seen = 0;

  task automatic commit();
    logic [NW-1:0] v;
    for (int c = 0; c < N; c++) begin
      for (int j = 0; j < N; j++)
        v[j*W +: W] = mode_m ? rows[c][j] : rows[j][c];
      outq.push_back(v);
    end
    fill_m = 0;
  endtask

  always @(negedge clock) begin
    bit ev, ee, in_go, out_go;
    logic [NW-1:0] ed;
    ev = (outq.size() > 0) || eos_m;
    ee = (outq.size() == 0) && eos_m;
    ed = (outq.size() > 0) ? outq[0] : '0;
    if (mv) begin
      chk("a_b", a_b, {N{blk_m}});
      chk("b_v", b_v, {N{ev}});
      chk("b_e", b_e, {N{ee}});
      chk("b_d", b_d, ed);
      chk("err", err, err_m);
      if (b_v[0] && b_b == '0) begin
        if (b_e[0]) eos_cnt++;
        else begin
          got.push_back(b_d);
          got_cyc.push_back(cyc);
        end
      end
      if (mon_ab && a_b[0]) ab_seen = 1;
    end
    if (reset) begin
      outq.delete();
      fill_m = 0; mode_m = 0;
      eos_m = 0; err_m = 0; blk_m = 1; mv = 1;
    end else if (mv) begin
      in_go  = (&a_v) && !blk_m;
      out_go = ev && (b_b == '0);
      if ((&a_v) && a_e != '0 && a_e != '1) err_m = 1;
      if (out_go) begin
        if (outq.size() > 0) void'(outq.pop_front());
        else eos_m = 0;
      end
      if (in_go) begin
        if (!a_e[0]) begin
          if (fill_m == 0) mode_m = mode;
          for (int c = 0; c < N; c++)
            rows[fill_m][c] = a_d[c*W +: W];
          fill_m++;
          if (fill_m == N) commit();
        end else begin
          if (fill_m != 0) begin
            for (int r = fill_m; r < N; r++)
              for (int c = 0; c < N; c++) rows[r][c] = '0;
            commit();
          end
          eos_m = 1;
        end
      end
      blk_m = ((outq.size() + N - 1) / N >= 2) || eos_m;
    end
  end

  function automatic logic [NW-1:0] mkrow(int base, int r);
    logic [NW-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'(base + r*16 + c);
    return v;
  endfunction

  function automatic logic [NW-1:0] tvec(int base, int c, int keep);
    logic [NW-1:0] v;
    for (int j = 0; j < N; j++)
      v[j*W +: W] = (j < keep) ? W'(base + j*16 + c) : '0;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_row(input logic [NW-1:0] d,
                          input logic [N-1:0] e);
    bit acc;
    int k;
    acc = 0;
    k = 0;
    a_v = '1; a_d = d; a_e = e;
    while (!acc && k < 200) begin
      @(negedge clock);
      acc = !a_b[0];
      @(posedge clock);
      #1;
      k++;
    end
    if (!acc) begin
      ncmp++; nbad++;
      $display("FAIL send_timeout got=blocked want=accepted");
    end
    a_v = '0; a_e = '0;
  endtask

  task automatic chk_got(input string nm, input int idx,
                         input logic [NW-1:0] exp);
    if (got.size() > idx) chk(nm, got[idx], exp);
    else chk({nm, "_missing"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ab", a_b, {N{1'b1}});
    chk("rst_bv", b_v, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    idle(1);
    chk("rst_ab_low", a_b, 0);

    // T1: single transpose block, first column right after row 7
    got.delete(); got_cyc.delete();
    for (int r = 0; r < N; r++) send_row(mkrow(0, r), '0);
    chk("t1_lat_v", b_v[0], 1);
    chk("t1_lat_d", b_d, tvec(0, 0, N));
    idle(12);
    chk("t1_cnt", got.size(), N);
    for (int c = 0; c < N; c++) chk_got("t1_col", c, tvec(0, c, N));

    // T2: three back-to-back blocks
    got.delete(); got_cyc.delete();
    ab_seen = 0; mon_ab = 1;
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < N; r++) send_row(mkrow(256*b, r), '0);
    idle(12);
    mon_ab = 0;
    chk("t2_cnt", got.size(), 3*N);
    if (got_cyc.size() == 3*N)
      chk("t2_span", got_cyc[3*N-1] - got_cyc[0], 3*N-1);
    chk("t2_no_ab", ab_seen, 0);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < N; c++)
        chk_got("t2_col", b*N + c, tvec(256*b, c, N));

    // T3: output stalled, both banks fill then drain
    b_b = '1;
    for (int r = 0; r < 2*N; r++) send_row(mkrow(1024, r), '0);
    chk("t3_ab_hi", a_b[0], 1);
    idle(3);
    chk("t3_ab_hold", a_b[0], 1);
    got.delete(); got_cyc.delete();
    b_b = '0;
    idle(20);
    chk("t3_cnt", got.size(), 2*N);
    chk_got("t3_first", 0, tvec(1024, 0, N));
    chk_got("t3_b1", N, tvec(1024 + 128, 0, N));
    chk("t3_ab_lo", a_b[0], 0);

    // T4: bypass block then transpose block, mode toggled mid-block
    got.delete(); got_cyc.delete();
    for (int r = 0; r < N; r++) begin
      mode = (r < 3);
      send_row(mkrow(1536, r), '0);
    end
    for (int r = 0; r < N; r++) begin
      mode = (r >= 4);
      send_row(mkrow(1792, r), '0);
    end
    mode = 0;
    idle(20);
    chk("t4_cnt", got.size(), 2*N);
    for (int c = 0; c < N; c++) begin
      chk_got("t4_byp", c, mkrow(1536, c));
      chk_got("t4_tp", N + c, tvec(1792, c, N));
    end

    // T5: EOS after three rows
    got.delete(); got_cyc.delete(); eos_cnt = 0;
    for (int r = 0; r < 3; r++) send_row(mkrow(2048, r), '0);
    send_row('0, '1);
    chk("t5_ab_hi", a_b[0], 1);
    idle(15);
    chk("t5_cnt", got.size(), N);
    chk("t5_eos", eos_cnt, 1);
    for (int c = 0; c < N; c++) chk_got("t5_pad", c, tvec(2048, c, 3));
    chk("t5_ab_lo", a_b[0], 0);

    // T6: mismatched EOS flags, then reset in mid-fill
    send_row(mkrow(2304, 0), 8'h01);
    chk("t6_err", err, 1);
    idle(5);
    chk("t6_err_sticky", err, 1);
    for (int r = 0; r < 3; r++) send_row(mkrow(2560, r), '0);
    reset = 1'b1;
    idle(1);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_bv", b_v, 0);
    chk("t6_rst_ab", a_b, {N{1'b1}});
    reset = 1'b0;
    idle(1);
    chk("t6_ab_lo", a_b, 0);
    chk("t6_bv_lo", b_v, 0);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/stream_tpose_pp.md
Name: stream_tpose_pp

Overview:
- Parametrised N×N streaming block transposer with ping-pong buffering; successor of the fixed 8-channel, 16-bit transpose page used between IDCT row and column passes.
- Accepts one N-element row vector per transfer on N lockstep input streams and emits column vectors on N lockstep output streams.
- Adds a per-block bypass mode, end-of-stream flush with zero padding, and a sticky protocol-error flag.

Parameters:
N, 8, channel count and block dimension (2..16)
W, 16, data width per channel
CW, 4, counter width, ≥ clog2(N)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
a_d  in  N*W  input data; channel i at [i*W+W-1:i*W]
a_e  in  N  input end-of-stream flag per channel
a_v  in  N  input valid per channel
a_b  out  N  input back-pressure, all bits identical
mode  in  1  0 = transpose, 1 = bypass (row order); sampled when row 0 of a block is accepted
b_d  out  N*W  output data, same packing as a_d
b_e  out  N  output end-of-stream flag, all bits identical
b_v  out  N  output valid, all bits identical
b_b  in  N  output back-pressure per channel
err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: both banks cleared to 0; wr_bank = rd_bank = 0; full[1:0] = 0; fill_cnt = drain_cnt = 0; eos_pend = 0. Outputs: a_b = all 1 while reset is high, all 0 on the first cycle after; b_v = 0; b_e = 0; b_d = 0; err = 0.
- Input transfer: happens when &a_v && !a_b[0]. Channels are never consumed individually.
- a_b: registered. a_b = full[wr_bank] | eos_pend. There is no combinational path from any input to a_b.
- Data row (a_e[0] = 0): bank[wr_bank][fill_cnt][i] <= channel i; fill_cnt increments.
  - When fill_cnt = 0, the block's mode bit is latched.
  - When fill_cnt = N-1: full[wr_bank] <= 1, wr_bank toggles, fill_cnt <= 0.
- EOS token (a_e[0] = 1):
  - If fill_cnt ≠ 0, the remaining rows fill_cnt..N-1 are zero-filled in the same cycle and the bank is committed as full.
  - eos_pend <= 1, and further input is blocked.
- Mismatch: if &a_v holds while a_e is not all-equal, err <= 1 (sticky until reset). The token is still accepted, using a_e[0].
- Output:
  - b_v = full[rd_bank] | (eos_pend & !full[0] & !full[1]).
  - Output transfer happens when b_v && !(|b_b).
  - Data vector, drain_cnt = c, transpose mode: channel j = bank[rd_bank][j][c].
  - Data vector, bypass mode: channel j = bank[rd_bank][c][j].
  - Each data transfer increments drain_cnt. At N-1: full[rd_bank] <= 0, rd_bank toggles, drain_cnt <= 0.
  - EOS vector (no full banks, eos_pend = 1): b_e = all 1, b_d = 0. On transfer, eos_pend <= 0 and input reopens the next cycle.
  - b_d = 0 whenever b_v = 0.
  - b_d/b_v/b_e are driven only from registers; there is no combinational path from a_* to b_*.
- Latency: the row N-1 accepted on edge k gives b_v = 1 with column 0 in the cycle after edge k, provided the other bank is empty.
- Throughput: with b_b = 0, continuous blocks stream at 1 vector/cycle in and 1 vector/cycle out with no bubbles.
- Simultaneous events:
  - Fill and drain of different banks in the same cycle is legal.
  - A bank freed on edge k is writable from cycle k+1; the registered a_b lags by one cycle.
  - An EOS accepted while both banks are full is impossible, because a_b is high.
- Reset mid-operation: all state is discarded and no partial block is emitted.

Test Plan:
1. Transpose, N=8, W=16: feed rows r=0..7 with channel c = r*16+c and b_b = 0 → output vector c, channel j = j*16+c; first b_v one cycle after row 7 is accepted.
2. Three back-to-back blocks with continuous a_v and b_b = 0 → 24 output vectors on consecutive cycles after the initial latency; a_b never asserts.
3. b_b = all 1 held → a_b rises after 16 row transfers (both banks full). Release b_b → 16 vectors drain in order, then a_b falls.
4. mode = 1 for block 0 and 0 for block 1, toggled mid-block → block 0 output equals its rows; block 1 is transposed; the toggle has no effect inside a block.
5. EOS after row 2 (rows 0..2 valid) → 8 vectors with channels 3..7 zero in transpose order, then one vector with b_e = all 1; a_b is high from the EOS until the b_e transfer.
6. a_v all 1 with a_e = 8'h01 → err = 1 and stays 1. Assert reset mid-fill → err = 0, b_v = 0, and a_b = 1 during reset, 0 the next cycle.
